sd_wb_arb: RTL
==============

Name: sd_wb_arb

Overview:
- Two-requester burst arbiter/sequencer that shares the single SD-core Wishbone master between two DMA engines.
  - Requester 0: the SD-read path, which writes memory.
  - Requester 1: the SD-write path, which reads memory.
- Grants whole bursts of BURST_LEN beats and generates incrementing addresses and the CTI/BTE encoding.
- Counts acks, detects a stalled slave via a watchdog, and reports per-burst completion or error to the owning requester.

Parameters:
- BURST_LEN, 16, beats per grant; legal range 2..128; 128 = one 512-byte block.
- TIMEOUT_CYC, 1024, consecutive BURST cycles without wbm_ack_i before abort; legal range 2..65535.

Ports:
- clk_50  in  1  sole clock; all logic on posedge.
- reset_n  in  1  synchronous, active-low reset.
- rqN_req  in  1  (N=0,1) burst request; sampled only in IDLE.
- rqN_we  in  1  burst direction: 1 = memory write, 0 = memory read.
- rqN_adr  in  32  burst start byte address, word aligned (bits [1:0] ignored).
- rqN_dat_w  in  32  write data for the current beat; requester advances it on rqN_beat.
- rqN_gnt  out  1  requester N owns the bus (BURST and DONE states).
- rqN_beat  out  1  combinational: wbm_ack_i & rqN_gnt & BURST; one transferred word.
- rqN_dat_r  out  32  wbm_dat_i passthrough; valid when rqN_beat.
- rqN_done  out  1  one-cycle pulse: burst completed normally.
- rqN_err  out  1  one-cycle pulse: burst aborted by the watchdog.
- wbm_clk_o  out  1  = clk_50.
- wbm_adr_o  out  32  burst address register.
- wbm_dat_i  in  32  Wishbone read data.
- wbm_dat_o  out  32  rqN_dat_w of the granted requester; 0 when idle.
- wbm_sel_o  out  4  constant 4'hF.
- wbm_cyc_o, wbm_stb_o  out  1  identical, registered.
- wbm_we_o  out  1  rqN_we latched at grant.
- wbm_ack_i  in  1  Wishbone acknowledge.
- wbm_cti_o  out  3  3'b010 during the burst; 3'b111 while beat_cnt == BURST_LEN-1; 3'b000 when idle.
- wbm_bte_o  out  2  constant 2'b00 (linear).

Behaviour:
- Reset (reset_n low at a clk_50 edge):
  - State = IDLE; cyc, stb, we, gnt, done, err = 0; adr = 0; beat_cnt = 0; wdog = 0; last_gnt = 1, so requester 0 wins the first contention.
  - Reset asserted mid-burst drops cyc/stb on that edge; no done or err pulse is generated.
- IDLE:
  - Any rqN_req high → next edge enters BURST.
  - On entry: cyc = stb = 1; adr = {rqN_adr[31:2], 2'b00}; we = rqN_we; gnt = N; beat_cnt = 0; wdog = 0.
  - Latency from req sampled high to cyc high: 1 cycle.
- Arbitration, both requesting in IDLE: grant the requester ≠ last_gnt (round robin); last_gnt updates at grant.
- BURST:
  - Each wbm_ack_i: adr += 4; beat_cnt += 1; wdog cleared.
  - Ack with beat_cnt == BURST_LEN-1: cyc = stb = 0 on the next edge → DONE.
  - No ack: wdog += 1. wdog reaching TIMEOUT_CYC-1 without an ack → cyc = stb = 0, rqN_err pulse, → IDLE. Partial beats are not retried.
  - rqN_req deasserting mid-burst is ignored; the burst always runs to completion or timeout.
- DONE:
  - rqN_done high for exactly 1 cycle; gnt held; → IDLE.
  - Next grant is 1 cycle after DONE, so bus idle time between bursts is 2 cycles.
- Wishbone:
  - Classic registered-feedback burst; stb stays high through wait states.
  - Address wrap at 32'hFFFFFFFC → 0 is unchecked.
- Simultaneous events:
  - Ack on the same cycle the watchdog expires: the ack wins; the beat counts and wdog clears.
  - Requests arriving during BURST or DONE are held off until IDLE.

Optional Feature:
- Macro SD_WB_ARB_RD_PRIO_EN.
  - Defined: fixed priority; requester 0 always wins when both request; last_gnt is unused.
  - Undefined: round robin as above.
- Fairness tests are gated on the macro.

Test Plan:
- Reset, then rq0_req=1, rq0_adr=32'h1000, rq0_we=1, slave acks every cycle:
  - cyc rises 1 cycle after req; adr steps 1000..103C.
  - cti = 010 ×15 then 111; 16 rq0_beat pulses.
  - rq0_done 1 cycle after the last ack; then IDLE.
- rq0 and rq1 both held high for 3 bursts:
  - Grants go 0, 1, 0.
  - With SD_WB_ARB_RD_PRIO_EN: grants go 0, 0, 0.
- Slave inserts 3 wait states per beat, rq1_we=0, wbm_dat_i = beat index:
  - stb held high throughout.
  - rq1_dat_r equals 0..15 at each rq1_beat.
  - Total burst 64 cycles.
- TIMEOUT_CYC=8, slave acks 5 beats then stops:
  - cyc drops after 8 idle cycles; rq0_err pulses once; rq0_done stays 0.
  - Next request granted normally.
- Reset asserted at beat 7 of a burst:
  - cyc/stb/gnt are 0 on the next edge; no done or err pulse.
  - Subsequent burst starts at the new rq_adr.
- rq1_req dropped after the first beat:
  - Burst still completes all 16 beats with rq1_done; no grant occurs until the next req.

Source files
------------

// File: rtl/sd_wb_arb.sv
// sd_wb_arb: shares one Wishbone burst master between the SD read (rq0) and SD write (rq1) DMA paths.
// Define SD_WB_ARB_RD_PRIO_EN for fixed priority to rq0; round robin otherwise.
module sd_wb_arb #(
    parameter int BURST_LEN   = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        clk_50,
    input  logic        reset_n,
    input  logic        rq0_req,
    input  logic        rq0_we,
    input  logic [31:0] rq0_adr,
    input  logic [31:0] rq0_dat_w,
    output logic        rq0_gnt,
    output logic        rq0_beat,
    output logic [31:0] rq0_dat_r,
    output logic        rq0_done,
    output logic        rq0_err,
    input  logic        rq1_req,
    input  logic        rq1_we,
    input  logic [31:0] rq1_adr,
    input  logic [31:0] rq1_dat_w,
    output logic        rq1_gnt,
    output logic        rq1_beat,
    output logic [31:0] rq1_dat_r,
    output logic        rq1_done,
    output logic        rq1_err,
    output logic        wbm_clk_o,
    output logic [31:0] wbm_adr_o,
    input  logic [31:0] wbm_dat_i,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    input  logic        wbm_ack_i,
    output logic [2:0]  wbm_cti_o,
    output logic [1:0]  wbm_bte_o
);
    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int WW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);
    localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_DONE} state_t;

    state_t         state;
    logic           cyc_q;
    logic           we_q;
    logic [31:0]    adr_q;
    logic [1:0]     gnt_q;
    logic [1:0]     done_q;
    logic [1:0]     err_q;
    logic [CW-1:0]  beat_cnt;
    logic [WW-1:0]  wdog;
    logic           pick;
    logic           in_burst;
    logic           unused_adr_bits;

    // Requester handshake: rqN_req is a level sampled only in IDLE; rqN_gnt answers it and stays
    // high until the burst ends. Each rqN_beat is one word moved, after which the requester advances.
`ifdef SD_WB_ARB_RD_PRIO_EN
    always_comb pick = ~rq0_req;
`else
    logic last_gnt;
    always_comb pick = (rq0_req && rq1_req) ? ~last_gnt : rq1_req;
`endif

    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            err_q    <= '0;
            beat_cnt <= '0;
            wdog     <= '0;
`ifndef SD_WB_ARB_RD_PRIO_EN
            last_gnt <= 1'b1;
`endif
        end else begin
            done_q <= '0;
            err_q  <= '0;
            case (state)
                ST_IDLE: begin
                    if (rq0_req || rq1_req) begin
                        state    <= ST_BURST;
                        cyc_q    <= 1'b1;
                        adr_q    <= pick ? {rq1_adr[31:2], 2'b00} : {rq0_adr[31:2], 2'b00};
                        we_q     <= pick ? rq1_we : rq0_we;
                        gnt_q    <= pick ? 2'b10 : 2'b01;
                        beat_cnt <= '0;
                        wdog     <= '0;
`ifndef SD_WB_ARB_RD_PRIO_EN
                        last_gnt <= pick;
`endif
                    end
                end
                ST_BURST: begin
                    // An ack always beats a watchdog expiry in the same cycle.
                    if (wbm_ack_i) begin
                        adr_q    <= adr_q + 32'd4;
                        beat_cnt <= beat_cnt + CW'(1);
                        wdog     <= '0;
                        if (beat_cnt == LAST_BEAT) begin
                            cyc_q  <= 1'b0;
                            done_q <= gnt_q;
                            state  <= ST_DONE;
                        end
                    end else if (wdog == WD_LAST) begin
                        cyc_q <= 1'b0;
                        err_q <= gnt_q;
                        gnt_q <= '0;
                        state <= ST_IDLE;
                    end else begin
                        wdog <= wdog + WW'(1);
                    end
                end
                ST_DONE: begin
                    gnt_q <= '0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_burst  = (state == ST_BURST);
    assign rq0_gnt   = gnt_q[0];
    assign rq1_gnt   = gnt_q[1];
    assign rq0_beat  = wbm_ack_i & gnt_q[0] & in_burst;
    assign rq1_beat  = wbm_ack_i & gnt_q[1] & in_burst;
    assign rq0_dat_r = wbm_dat_i;
    assign rq1_dat_r = wbm_dat_i;
    assign rq0_done  = done_q[0];
    assign rq1_done  = done_q[1];
    assign rq0_err   = err_q[0];
    assign rq1_err   = err_q[1];

    assign wbm_clk_o = clk_50;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = gnt_q[1] ? rq1_dat_w : (gnt_q[0] ? rq0_dat_w : 32'h0);
    assign wbm_sel_o = 4'hF;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_cti_o = in_burst ? ((beat_cnt == LAST_BEAT) ? 3'b111 : 3'b010) : 3'b000;
    assign wbm_bte_o = 2'b00;

    assign unused_adr_bits = &{1'b0, rq0_adr[1:0], rq1_adr[1:0]};
endmodule
